// File: rtl/lane_pkg.sv
// Shared lane-assembly constants, FSM encoding and a lane-slice helper.
// Pure declarations: no latency, no flow control.
package lane_pkg;
  localparam int NUM_LANES = 25;
  localparam int LANE_W    = 64;
  localparam int NUM_W     = 32;
  localparam int IDX_W     = 5;
  localparam int STATE_W   = NUM_LANES * LANE_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_OUT  = 2'd3
  } lane_fsm_e;

  // Lane i of a flat state lives at bits [LANE_W*i +: LANE_W].
  function automatic logic [LANE_W-1:0] lane_slice(input logic [STATE_W-1:0] flat,
                                                   input logic [IDX_W-1:0]   idx);
    return flat[LANE_W*idx +: LANE_W];
  endfunction
endpackage

// File: rtl/lane_assembler_if.sv
// Reader-side request/lane bus plus the downstream state valid/ready handshake.
// Master is the assembler; slave is the reader/consumer side.
interface lane_assembler_if;
  import lane_pkg::*;

  logic                   read_data;
  logic [NUM_W-1:0]       num;
  logic                   lane_valid;
  logic [LANE_W-1:0]      lane_in;
  logic                   state_valid;
  logic                   state_ready;
  logic [STATE_W-1:0]     state_out;

  modport master (
    output read_data, num, state_valid, state_out,
    input  lane_valid, lane_in, state_ready
  );

  modport slave (
    input  read_data, num, state_valid, state_out,
    output lane_valid, lane_in, state_ready
  );
endinterface

// File: rtl/lane_buffer.sv
// 25 x LANE_W register file, one lane written per cycle; flat read-out visible the cycle after a write.
// No flow control: the writer owns sequencing.
module lane_buffer
  import lane_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [LANE_W-1:0]  wr_dat,
  output logic [STATE_W-1:0] rd_flat
);
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_slot
    logic [LANE_W-1:0] slot;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        slot <= '0;
      end else if (wr_en && (wr_idx == IDX_W'(i))) begin
        slot <= wr_dat;
      end
    end

    assign rd_flat[LANE_W*i +: LANE_W] = slot;
  end
endmodule

// File: rtl/lane_assembler.sv
// Requests lanes 0..24 from the lane reader (2 cycles/lane, state_valid after 50 edges); holds the state until state_ready.
// Stalls in WAIT without timeout; LANE_PARITY_EN adds a registered XOR-of-lanes output parity_out.
module lane_assembler
  import lane_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  lane_assembler_if.master bus
`ifdef LANE_PARITY_EN
  ,output logic [LANE_W-1:0] parity_out
`endif
);
  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] REQ  = ST_REQ;
  localparam logic [1:0] WAIT = ST_WAIT;
  localparam logic [1:0] OUT  = ST_OUT;

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic             lane_acc;

  // Lanes are only taken while waiting; anything earlier is a stale/spurious strobe.
  assign lane_acc = (state == WAIT) && bus.lane_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          idx   <= '0;
          state <= REQ;
        end
        REQ:  state <= WAIT;
        WAIT: if (bus.lane_valid) begin
          if (idx == IDX_W'(NUM_LANES - 1)) begin
            state <= OUT;
          end else begin
            idx   <= idx + 1'b1;
            state <= REQ;
          end
        end
        OUT:  if (bus.state_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.read_data   = (state == REQ);
  assign bus.num         = NUM_W'(idx);
  assign bus.state_valid = (state == OUT);
  assign busy            = (state != IDLE);

  lane_buffer u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (lane_acc),
    .wr_idx  (idx),
    .wr_dat  (bus.lane_in),
    .rd_flat (bus.state_out)
  );

`ifdef LANE_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_out <= '0;
    end else if ((state == IDLE) && start) begin
      parity_out <= '0;
    end else if (lane_acc) begin
      parity_out <= parity_out ^ bus.lane_in;
    end
  end
`endif
endmodule

// File: tb/tb_lane_assembler.sv
// Self-checking bench for lane_assembler: a reader model answers each read_data with a lane chosen by the bench.
// Expected state is the concatenation of the lanes handed out, indexed by request order.
module tb_lane_assembler;
  import lane_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy;
`ifdef LANE_PARITY_EN
  logic [LANE_W-1:0] parity_out;
`endif

  lane_assembler_if bus();

  int total  = 0;
  int passed = 0;
  logic [LANE_W-1:0]  vals [NUM_LANES];
  logic [STATE_W-1:0] exp_flat = '0;

  always #5 clk = ~clk;

  lane_assembler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .busy  (busy),
    .bus   (bus)
`ifdef LANE_PARITY_EN
    ,.parity_out (parity_out)
`endif
  );

  task automatic step();
    @(negedge clk);
  endtask

  // mode 0: 0x0101..01*(i+1); mode 1: random; mode 2: one-hot 1<<i.
  // abort_at >= 0 stops once the FSM is waiting for that lane.
  task automatic fill(input int mode, input int stall_lane, input int stall_cyc,
                      input int ready_delay, input bit spur, input int abort_at);
    int n;
    logic [LANE_W-1:0] par;
    for (int k = 0; k < NUM_LANES; k++) begin
      case (mode)
        0:       vals[k] = 64'h0101_0101_0101_0101 * (k + 1);
        1:       vals[k] = {$urandom, $urandom};
        default: vals[k] = 64'h1 << k;
      endcase
    end
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < NUM_LANES; k++) begin
      n = 0;
      while (bus.read_data !== 1'b1 && n < 8) begin
        step();
        n++;
      end
      total++;
      if (bus.read_data !== 1'b1 || n != 0) begin
        $display("FAIL req lane%0d: read_data=%b after %0d cycles, want 1 after 0", k, bus.read_data, n);
        if (bus.read_data !== 1'b1) return;
      end else passed++;
      total++;
      if (bus.num !== NUM_W'(k)) $display("FAIL num lane%0d: got %0d want %0d", k, bus.num, k);
      else passed++;
      if (spur && k == 3) begin
        bus.lane_valid = 1'b1;
        bus.lane_in    = ~vals[k];
      end
      if (spur && k == 5) start = 1'b1;
      step();
      start = 1'b0;
      bus.lane_valid = 1'b0;
      if (k == abort_at) return;
      for (int s = 0; s < ((k == stall_lane) ? stall_cyc : 0); s++) begin
        total++;
        if (bus.read_data !== 1'b0 || bus.num !== NUM_W'(k))
          $display("FAIL stall lane%0d: read_data=%b num=%0d want 0/%0d", k, bus.read_data, bus.num, k);
        else passed++;
        step();
      end
      if (k == NUM_LANES - 1) begin
        total++;
        if (bus.state_valid !== 1'b0) $display("FAIL early_valid: state_valid=%b want 0", bus.state_valid);
        else passed++;
      end
      bus.lane_valid = 1'b1;
      bus.lane_in    = vals[k];
      step();
      bus.lane_valid = 1'b0;
      bus.lane_in    = '0;
    end
    for (int i = 0; i < NUM_LANES; i++) exp_flat[LANE_W*i +: LANE_W] = vals[i];
    total++;
    if (bus.state_valid !== 1'b1) $display("FAIL state_valid: got %b want 1", bus.state_valid);
    else passed++;
    for (int i = 0; i < NUM_LANES; i++) begin
      total++;
      if (lane_slice(bus.state_out, IDX_W'(i)) !== vals[i])
        $display("FAIL slot%0d: got %h want %h", i, lane_slice(bus.state_out, IDX_W'(i)), vals[i]);
      else passed++;
    end
`ifdef LANE_PARITY_EN
    par = '0;
    for (int i = 0; i < NUM_LANES; i++) par ^= vals[i];
    total++;
    if (parity_out !== par) $display("FAIL parity: got %h want %h", parity_out, par);
    else passed++;
`else
    par = '0;
`endif
    for (int s = 0; s < ready_delay; s++) begin
      step();
      total++;
      if (bus.state_valid !== 1'b1 || bus.state_out !== exp_flat || bus.read_data !== 1'b0)
        $display("FAIL hold cycle%0d: state_valid=%b read_data=%b stable=%b want 1/0/1",
                 s, bus.state_valid, bus.read_data, bus.state_out === exp_flat);
      else passed++;
    end
    bus.state_ready = 1'b1;
    start = 1'b1;
    step();
    bus.state_ready = 1'b0;
    start = 1'b0;
    total++;
    if (bus.state_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL handshake: state_valid=%b busy=%b want 0/0", bus.state_valid, busy);
    else passed++;
    step();
    total++;
    if (busy !== 1'b0 || bus.read_data !== 1'b0 || bus.state_out !== exp_flat)
      $display("FAIL post_out: busy=%b read_data=%b kept=%b want 0/0/1",
               busy, bus.read_data, bus.state_out === exp_flat);
    else passed++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int c = 0; c < 4; c++) begin
      start = c[0];
      step();
      total++;
      if (bus.read_data !== 1'b0 || busy !== 1'b0 || bus.state_valid !== 1'b0 || bus.state_out !== '0)
        $display("FAIL reset_idle c%0d: read_data=%b busy=%b state_valid=%b out_zero=%b want 0/0/0/1",
                 c, bus.read_data, busy, bus.state_valid, bus.state_out === '0);
      else passed++;
    end
    start = 1'b0;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      total++;
      if (bus.read_data !== 1'b0 || busy !== 1'b0)
        $display("FAIL reset_release c%0d: read_data=%b busy=%b want 0/0", c, bus.read_data, busy);
      else passed++;
    end
  endtask

  task automatic test_zero_wait();
    fill(0, -1, 0, 0, 1'b0, -1);
  endtask

  task automatic test_stalls();
    fill(1, 7, 3, 10, 1'b0, -1);
  endtask

  task automatic test_spurious();
    bus.lane_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      bus.lane_in = {$urandom, $urandom};
      step();
      total++;
      if (busy !== 1'b0 || bus.state_out !== exp_flat)
        $display("FAIL idle_lane_valid c%0d: busy=%b kept=%b want 0/1", c, busy, bus.state_out === exp_flat);
      else passed++;
    end
    bus.lane_valid = 1'b0;
    bus.lane_in    = '0;
    fill(1, -1, 0, 2, 1'b1, -1);
  endtask

  task automatic test_reset_mid_fill();
    fill(0, -1, 0, 0, 1'b0, 12);
    total++;
    if (busy !== 1'b1 || bus.num !== NUM_W'(12))
      $display("FAIL mid_fill_pre: busy=%b num=%0d want 1/12", busy, bus.num);
    else passed++;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.read_data !== 1'b0 || busy !== 1'b0 || bus.state_valid !== 1'b0 ||
        bus.state_out !== '0 || bus.num !== '0)
      $display("FAIL mid_fill_reset: read_data=%b busy=%b state_valid=%b out_zero=%b num=%0d want 0/0/0/1/0",
               bus.read_data, busy, bus.state_valid, bus.state_out === '0, bus.num);
    else passed++;
    step();
    rst_n = 1'b1;
    step();
    step();
    total++;
    if (busy !== 1'b0 || bus.read_data !== 1'b0)
      $display("FAIL mid_fill_release: busy=%b read_data=%b want 0/0", busy, bus.read_data);
    else passed++;
    fill(0, -1, 0, 1, 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 3; r++)
      fill(1, $urandom_range(0, NUM_LANES - 1), $urandom_range(1, 4), $urandom_range(0, 3), 1'b0, -1);
  endtask

  task automatic test_parity();
`ifdef LANE_PARITY_EN
    fill(2, -1, 0, 0, 1'b0, -1);
    total++;
    if (parity_out !== 64'h0000_0000_01FF_FFFF)
      $display("FAIL parity_onehot: got %h want 00000000_01ffffff", parity_out);
    else passed++;
`endif
  endtask

  initial begin
    bus.lane_valid  = 1'b0;
    bus.lane_in     = '0;
    bus.state_ready = 1'b0;
    test_reset();
    test_zero_wait();
    test_stalls();
    test_spurious();
    test_reset_mid_fill();
    test_back_to_back();
    test_parity();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/lane_assembler.md
Name: lane_assembler

Overview:
- Sits directly downstream of the per-bit lane reader. That reader returns one 64-bit lane (bit `num` of each of 64 25-bit slice words) per `readData` rising edge.
- This block sequences the reader: it requests lanes 0..24 in order, buffers them into a 1600-bit (25x64) state, and presents that state to the next stage over a valid/ready handshake.
- It is the bridge from file-sourced slices to the state-processing datapath.

Parameters:
- NUM_LANES, 25, number of lanes per state; also the lane-index range 0..NUM_LANES-1.
- LANE_W, 64, bits per lane; equals the reader's pipe width.
- NUM_W, 32, width of the lane-index output; matches the reader's `num` input.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin assembling one state; sampled only in IDLE.
- read_data  output  1  one-cycle request pulse to the reader; drives its readData.
- num  output  NUM_W  index of the lane being requested; stable from the REQ cycle until the lane is accepted.
- lane_valid  input  1  the reader's lane_in is valid this cycle.
- lane_in  input  LANE_W  lane data from the reader's pipe.
- busy  output  1  high in every state except IDLE.
- state_valid  output  1  state_out holds a complete state.
- state_ready  input  1  downstream accepts the state.
- state_out  output  NUM_LANES*LANE_W  assembled state; lane i occupies bits [LANE_W*i +: LANE_W].

Behaviour:
- Reset (async assert, sync release) drives all outputs to 0 and sets the FSM to IDLE, idx=0, lane buffer=0.
- Reset asserted mid-operation abandons the partial state. No read_data pulse is emitted on reset release.
- FSM states: IDLE, REQ, WAIT, OUT.
- IDLE: start=1 -> idx<=0, go to REQ. Otherwise stay.
- REQ: read_data=1 for exactly this one cycle; num=idx; next state WAIT.
- WAIT: on lane_valid=1, write lane_in into slot idx.
  - If idx==NUM_LANES-1: go to OUT.
  - Else: idx<=idx+1, go to REQ.
  - lane_valid=0: stay in WAIT indefinitely. There is no timeout.
- OUT: state_valid=1 and state_out is held stable. On state_ready=1, complete the handshake, clear state_valid next cycle, and go to IDLE.
- lane_valid outside WAIT is ignored, including lane_valid in the REQ cycle itself.
- start outside IDLE is ignored. This includes start in the same cycle that the OUT handshake completes; a new start must be presented in IDLE.
- num is zero-extended from idx to NUM_W. idx is a 5-bit counter and never exceeds NUM_LANES-1 (no wrap).
- Minimum latency: start sampled at edge 0 -> state_valid high after edge 50, i.e. 2 cycles per lane.
- state_out is registered. It keeps the last assembled state after OUT until the next lane write overwrites a slot.

Optional Feature:
- Macro: LANE_PARITY_EN.
- Defined: adds output port `parity_out`, LANE_W wide, registered. It is cleared on start and XOR-accumulated with each accepted lane_in. It is valid while state_valid=1 and equals the XOR of all 25 lanes.
- Not defined: port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package `lane_pkg`:
  - constants NUM_LANES, LANE_W, NUM_W, IDX_W=5;
  - FSM state enum (IDLE, REQ, WAIT, OUT);
  - lane-slice helper function.
- One natural sub-module, `lane_buffer`: 25xLANE_W register file with write-enable, index, data and flat read-out. The FSM, counter and handshake stay in lane_assembler.

Test Plan:
- Reset then idle: rst_n low, start pulses -> read_data, busy, state_valid, state_out all 0.
- Zero-wait fill: start; reader model returns lane_in=64'h0101_0101_0101_0101*(num+1) with lane_valid one cycle after each read_data -> 25 read_data pulses with num=0..24 in order; state_valid high after edge 50; slot i == pattern(i).
- Back-pressure and stalls:
  - lane_valid delayed 3 cycles on lane 7 -> num stays 7 and no extra read_data pulse;
  - state_ready held low 10 cycles -> state_out stable and state_valid high throughout.
- Spurious inputs: lane_valid during a REQ cycle and while in IDLE; start while busy -> no slot written, no restart, and the sequence completes normally.
- Reset mid-fill: assert rst_n low while in WAIT with num=12 -> outputs 0, FSM in IDLE; a subsequent start restarts at num=0.
- LANE_PARITY_EN build: lanes = one-hot 64'h1<<i -> parity_out == 64'h0000_0000_01FF_FFFF at state_valid.
